// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encodings and default bus widths,
// reused by the requester, address decoder and register banks.
package apb_pkg;

  localparam int unsigned APB_AWIDTH = 4;
  localparam int unsigned APB_DWIDTH = 8;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with PREADY low; flags the tick that reaches TIMEOUT.
// TIMEOUT = 0 disables expiry. The counter saturates instead of wrapping.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != '1)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Asserted on the wait tick that would bring the count up to TIMEOUT
  assign expired = (TIMEOUT != 0) && enable && (r_count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: one outstanding single-beat command, SETUP/ACCESS sequencing,
// registered bus outputs and a one-cycle response pulse with error/timeout status.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned AWIDTH  = APB_AWIDTH,
  parameter int unsigned DWIDTH  = APB_DWIDTH,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e r_state, w_next;

  logic              r_psel, r_penable, r_pwrite;
  logic [AWIDTH-1:0] r_paddr;
  logic [DWIDTH-1:0] r_pwdata;
  logic              r_rsp_valid, r_rsp_err, r_rsp_timeout;
  logic [DWIDTH-1:0] r_rsp_rdata;
  logic              w_accept, w_wait, w_expired, w_done;

  assign cmd_ready = (r_state == APB_IDLE) && PRESETn;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_wait    = (r_state == APB_ACCESS) && !PREADY;
  assign w_done    = (r_state == APB_ACCESS) && (PREADY || w_expired);

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (w_accept),
    .enable  (w_wait),
    .expired (w_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= APB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      APB_IDLE:   if (w_accept) w_next = APB_SETUP;
      APB_SETUP:  w_next = APB_ACCESS;
      APB_ACCESS: if (w_done) w_next = APB_IDLE;
      default:    w_next = APB_IDLE;
    endcase
  end

  // Bus controls are registered from the next state so they line up with r_state
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_psel    <= (w_next != APB_IDLE);
      r_penable <= (w_next == APB_ACCESS);
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        if (cmd_write) begin
          r_pwdata <= cmd_wdata;
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_rsp_valid <= w_done;
      if (w_done) begin
        r_rsp_timeout <= !PREADY;
        r_rsp_err     <= PREADY ? PSLVERR : 1'b1;
        r_rsp_rdata   <= (PREADY && !r_pwrite) ? PRDATA : '0;
      end
    end
  end

  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_rdata   = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: vector table, randomized transfers against a
// transaction-level model, and hand sequences for reset and back-to-back use.
module tb_apb_master;

  localparam int TO = 15;

  logic       PCLK, PRESETn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [3:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY, PSLVERR;

  apb_master #(
    .AWIDTH  (4),
    .DWIDTH  (8),
    .TIMEOUT (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       wr;
    logic [3:0] a;
    logic [7:0] d;
    int         waits;
    logic       serr;
    logic [7:0] prd;
    logic [7:0] e_rdata;
    logic       e_err;
    logic       e_to;
    int         e_lat;
    int         e_acc;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] last_wd  = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Transaction-level expectation from the protocol rules
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic to;
    r         = v;
    to        = (TO != 0) && (v.waits >= TO);
    r.e_to    = to;
    r.e_acc   = to ? TO : v.waits + 1;
    r.e_lat   = r.e_acc + 2;
    r.e_err   = to | v.serr;
    r.e_rdata = (v.wr || to) ? 8'h00 : v.prd;
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int         acc, lat;
    logic       got, bus_ok;
    logic [7:0] rd;
    logic       er, tm;
    acc = 0; lat = 0; got = 1'b0; bus_ok = 1'b1;
    rd = 8'h00; er = 1'b0; tm = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.a; cmd_wdata = v.d;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge PCLK);
    chk({tag, ".accept"}, int'(cmd_ready), 1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    cmd_wdata = 8'($urandom);
    cmd_addr  = 4'($urandom);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        got = 1'b1; lat = k;
        rd = rsp_rdata; er = rsp_err; tm = rsp_timeout;
        if (PSEL || PENABLE) bus_ok = 1'b0;
      end else if (k == 1) begin
        if (!(PSEL && !PENABLE)) bus_ok = 1'b0;
      end else begin
        if (!(PSEL && PENABLE)) bus_ok = 1'b0;
      end
      if (PSEL && ((PADDR != v.a) || (PWRITE != v.wr) ||
                   (PWDATA != (v.wr ? v.d : last_wd)))) bus_ok = 1'b0;
      if (PSEL && PENABLE) begin
        acc++;
        PREADY  = (acc > v.waits);
        PRDATA  = PREADY ? v.prd : 8'($urandom);
        PSLVERR = PREADY ? v.serr : 1'($urandom);
      end else begin
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = 8'($urandom);
      end
    end
    if (v.wr) last_wd = v.d;
    chk({tag, ".latency"}, lat, v.e_lat);
    chk({tag, ".access_cycles"}, acc, v.e_acc);
    chk({tag, ".rdata"}, int'(rd), int'(v.e_rdata));
    chk({tag, ".err"}, int'(er), int'(v.e_err));
    chk({tag, ".timeout"}, int'(tm), int'(v.e_to));
    chk({tag, ".bus"}, int'(bus_ok), 1);
    @(negedge PCLK);
    chk({tag, ".pulse_once"}, int'(rsp_valid), 0);
    chk({tag, ".rdata_hold"}, int'(rsp_rdata), int'(v.e_rdata));
  endtask

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, setups, last, n_acc;
    logic acc_now, seen_rsp;
    vec_t rv;

    //         wr    a      d      waits serr  prd    e_rdata e_err e_to lat acc
    tbl[0] = '{1'b1, 4'h2, 8'hA5,  0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0,  3,  1};
    tbl[1] = '{1'b0, 4'h6, 8'h00,  2, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0,  5,  3};
    tbl[2] = '{1'b0, 4'hF, 8'h00,  0, 1'b1, 8'h77, 8'h77, 1'b1, 1'b0,  3,  1};
    tbl[3] = '{1'b0, 4'h3, 8'h00, 30, 1'b0, 8'h99, 8'h00, 1'b1, 1'b1, 17, 15};
    tbl[4] = '{1'b1, 4'h9, 8'h5A, 14, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 17, 15};
    tbl[5] = '{1'b1, 4'h1, 8'hC3, 15, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 17, 15};
    tbl[6] = '{1'b1, 4'h8, 8'h0F,  1, 1'b1, 8'hEE, 8'h00, 1'b1, 1'b0,  4,  2};

    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 4'h0; cmd_wdata = 8'h00;
    PRDATA = 8'h00; PREADY = 1'b0; PSLVERR = 1'b0;
    #12;
    chk("reset.cmd_ready", int'(cmd_ready), 0);
    chk("reset.bus", int'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 0);
    chk("reset.rsp", int'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("reset.ready_after", int'(cmd_ready), 1);

    foreach (tbl[i]) run_txn(tbl[i], $sformatf("row%0d", i));

    for (int i = 0; i < 30; i++) begin
      rv.wr    = 1'($urandom);
      rv.a     = 4'($urandom);
      rv.d     = 8'($urandom);
      rv.waits = $urandom_range(0, 18);
      rv.serr  = 1'($urandom);
      rv.prd   = 8'($urandom);
      run_txn(model(rv), $sformatf("rand%0d", i));
    end

    // Back-to-back writes with cmd_valid held
    @(negedge PCLK);
    PREADY = 1'b1; PSLVERR = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 8'h10;
    pulses = 0; setups = 0; last = 0; n_acc = 0;
    for (int e = 0; e <= 15; e++) begin
      acc_now = cmd_valid && cmd_ready;
      @(posedge PCLK);
      #1;
      if (acc_now) begin
        n_acc++;
        if (n_acc == 4) cmd_valid = 1'b0;
        cmd_addr  = 4'(n_acc);
        cmd_wdata = 8'h10 + 8'(n_acc);
      end
      @(negedge PCLK);
      if (rsp_valid) begin
        pulses++;
        last = e + 1;
      end
      if (PSEL && !PENABLE) setups++;
    end
    cmd_valid = 1'b0;
    last_wd = 8'h13;
    chk("b2b.accepts", n_acc, 4);
    chk("b2b.pulses", pulses, 4);
    chk("b2b.setups", setups, 4);
    chk("b2b.total_cycles", last, 12);

    // Reset while in ACCESS
    @(negedge PCLK);
    PREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h5;
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_mid.in_access", int'(PSEL && PENABLE), 1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("rst_mid.bus_idle", int'({PSEL, PENABLE}), 0);
    chk("rst_mid.cmd_ready", int'(cmd_ready), 0);
    seen_rsp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      if (rsp_valid) seen_rsp = 1'b1;
    end
    PRESETn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      if (rsp_valid) seen_rsp = 1'b1;
    end
    chk("rst_mid.no_rsp", int'(seen_rsp), 0);
    last_wd = 8'h00;
    rv = '{1'b0, 4'h4, 8'h00, 1, 1'b0, 8'h5E, 8'h00, 1'b0, 1'b0, 0, 0};
    run_txn(model(rv), "rst_mid.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
